stream_multi_matcher: RTL and testbench

- Parametrised successor to the single-pattern streaming matcher: scans a byte stream, delivered WIDTH bits per cycle, for up to NUM_PAT flagged strings at once.
- The data word passes through a fixed-latency pipeline unchanged.
- Each output word carries per-pattern match pulses aligned to it, plus sticky per-pattern flags.
- Sits between the packet ingress path and the sniffer's flag/logging logic.

---
 rtl/stream_match_pkg.sv | 13 +
 rtl/pattern_window_cmp.sv | 38 +++
 rtl/stream_multi_matcher.sv | 128 ++++++++++++
 tb/tb_stream_multi_matcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_match_pkg.sv
// Shared types and defaults for the multi-pattern stream matcher.
package stream_match_pkg;
  localparam int BYTE_W      = 8;
  localparam int LEN_W       = 5;
  localparam int COUNT_W     = 16;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_PAT = 4;
  localparam int DEF_MAX_LEN = 17;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [DEF_MAX_LEN-1:0] pattern_t;
  typedef logic [LEN_W-1:0] len_t;
endpackage

// File: rtl/pattern_window_cmp.sv
// Combinational compare of one pattern against every byte offset of the
// current word. Window byte 0 (LSBs) is the oldest byte; data byte b sits at MAX_LEN-1+b.
module pattern_window_cmp
  import stream_match_pkg::*;
#(
  parameter int BYTES   = DEF_WIDTH / BYTE_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic [(MAX_LEN-1+BYTES)*BYTE_W-1:0] window,
  input  logic [LEN_W-1:0]                    fill,
  input  logic [MAX_LEN*BYTE_W-1:0]           pattern,
  input  logic [LEN_W-1:0]                    len,
  input  logic                                en,
  input  logic                                valid,
  output logic                                hit
);
  logic ok;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    hit = 1'b0;
    ok  = 1'b0;
    if (valid && en && len != '0 && int'(len) <= MAX_LEN) begin
      for (int b = 0; b < BYTES; b++) begin
        // Every byte of the candidate must have arrived since the last clear.
        ok = (int'(fill) + b + 1 >= int'(len));
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < int'(len)) begin
            if (window[(MAX_LEN + b - int'(len) + i)*BYTE_W +: BYTE_W] !=
                pattern[i*BYTE_W +: BYTE_W])
              ok = 1'b0;
          end
        end
        hit = hit | ok;
      end
    end
  end
endmodule

// File: rtl/stream_multi_matcher.sv
// Streaming multi-pattern matcher with fixed-latency data passthrough.
// Define STREAM_MATCH_COUNT_EN to build the per-pattern saturating match counters.
module stream_multi_matcher
  import stream_match_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_PAT    = DEF_NUM_PAT,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int PIPE_DEPTH = 6
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              clear,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              data_in_valid,
  input  logic [NUM_PAT*MAX_LEN*BYTE_W-1:0] patterns,
  input  logic [NUM_PAT*LEN_W-1:0]          pattern_len,
  input  logic [NUM_PAT-1:0]                pattern_en,
  output logic [WIDTH-1:0]                  data_out,
  output logic                              data_out_valid,
  output logic [NUM_PAT-1:0]                match_pulse,
  output logic [NUM_PAT-1:0]                match,
  output logic                              match_any,
  output logic [NUM_PAT*COUNT_W-1:0]        match_count
);
  localparam int BYTES  = WIDTH / BYTE_W;
  localparam int HIST_B = MAX_LEN - 1;
  localparam int WIN_W  = (HIST_B + BYTES) * BYTE_W;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               valid;
    logic [NUM_PAT-1:0] hit;
  } stage_t;

  logic [HIST_B*BYTE_W-1:0] history;
  len_t                     fill;
  logic [WIN_W-1:0]         window;
  logic [NUM_PAT-1:0]       hit;
  logic [NUM_PAT-1:0]       match_next;
  stage_t                   pipe [PIPE_DEPTH];

  always_comb begin
    window                     = '0;
    window[HIST_B*BYTE_W-1:0]  = history;
    for (int b = 0; b < BYTES; b++)
      window[(HIST_B+b)*BYTE_W +: BYTE_W] = data_in[WIDTH-1-b*BYTE_W -: BYTE_W];
  end

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_cmp
    pattern_window_cmp #(.BYTES(BYTES), .MAX_LEN(MAX_LEN)) u_cmp (
      .window (window),
      .fill   (fill),
      .pattern(patterns[k*MAX_LEN*BYTE_W +: MAX_LEN*BYTE_W]),
      .len    (pattern_len[k*LEN_W +: LEN_W]),
      .en     (pattern_en[k]),
      .valid  (data_in_valid),
      .hit    (hit[k])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (data_in_valid) begin
      history <= window[WIN_W-1:BYTES*BYTE_W];
      if (int'(fill) + BYTES >= HIST_B) fill <= len_t'(HIST_B);
      else                              fill <= fill + len_t'(BYTES);
    end
  end

  // NOTE: the pipeline array is reset because its last stage drives outputs with defined reset values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{data: data_in, valid: data_in_valid, hit: hit};
      for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign data_out       = pipe[PIPE_DEPTH-1].data;
  assign data_out_valid = pipe[PIPE_DEPTH-1].valid;
  assign match_pulse    = pipe[PIPE_DEPTH-1].hit;
  assign match_next     = match | match_pulse;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match     <= '0;
      match_any <= 1'b0;
    end else if (clear) begin
      match     <= '0;
      match_any <= 1'b0;
    end else begin
      match     <= match_next;
      match_any <= |match_next;
    end
  end

`ifdef STREAM_MATCH_COUNT_EN
  logic [COUNT_W-1:0] count [NUM_PAT];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_PAT; k++) count[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_PAT; k++) count[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PAT; k++)
        if (match_pulse[k] && count[k] != '1) count[k] <= count[k] + 1'b1;
    end
  end

  always_comb begin
    match_count = '0;
    for (int k = 0; k < NUM_PAT; k++) match_count[k*COUNT_W +: COUNT_W] = count[k];
  end
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_stream_multi_matcher.sv
// Directed bench for stream_multi_matcher: latency, cross-word and multi-pattern
// matches, clear, degenerate configs and the optional counters.
module tb_stream_multi_matcher;
  localparam int NP = 4;
  localparam int ML = 17;
`ifdef STREAM_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              n_rst;
  logic              clear;
  logic [31:0]       data_in;
  logic              data_in_valid;
  logic [NP*ML*8-1:0] patterns;
  logic [NP*5-1:0]   pattern_len;
  logic [NP-1:0]     pattern_en;
  logic [31:0]       data_out;
  logic              data_out_valid;
  logic [NP-1:0]     match_pulse;
  logic [NP-1:0]     match;
  logic              match_any;
  logic [NP*16-1:0]  match_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] st_data  [0:127];
  logic        st_valid [0:127];
  logic        st_clr   [0:127];
  logic [3:0]  st_hit   [0:127];
  int          st_n;
  logic [31:0] ob_data  [0:127];
  logic        ob_valid [0:127];
  logic [3:0]  ob_pulse [0:127];

  stream_multi_matcher #(.WIDTH(32), .NUM_PAT(NP), .MAX_LEN(ML), .PIPE_DEPTH(6)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .patterns      (patterns),
    .pattern_len   (pattern_len),
    .pattern_en    (pattern_en),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .match_pulse   (match_pulse),
    .match         (match),
    .match_any     (match_any),
    .match_count   (match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i < s.len()) r[31-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic set_pattern(input int k, input string s, input int len);
    for (int i = 0; i < ML; i++) patterns[(k*ML+i)*8 +: 8] = 8'h00;
    for (int i = 0; i < s.len(); i++) patterns[(k*ML+i)*8 +: 8] = s[i];
    pattern_len[k*5 +: 5] = 5'(len);
  endtask

  task automatic push(input logic [31:0] d, input logic v, input logic c, input logic [3:0] h);
    st_data[st_n]  = d;
    st_valid[st_n] = v;
    st_clr[st_n]   = c;
    st_hit[st_n]   = h;
    st_n++;
  endtask

  // Drives the queued cycles, then checks each output cycle against the entry
  // six edges earlier; any clear in that span means the word was flushed.
  task automatic run_seq(input string name);
    bit          flushed;
    logic [31:0] e_data;
    logic        e_valid;
    logic [3:0]  e_hit;
    for (int i = 0; i < 7; i++) push(32'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < st_n; i++) begin
      data_in       = st_data[i];
      data_in_valid = st_valid[i];
      clear         = st_clr[i];
      @(negedge clk);
      ob_data[i]  = data_out;
      ob_valid[i] = data_out_valid;
      ob_pulse[i] = match_pulse;
    end
    data_in = '0; data_in_valid = 1'b0; clear = 1'b0;
    for (int j = 0; j < st_n; j++) begin
      flushed = (j < 5);
      for (int c = j - 5; c <= j; c++)
        if (c >= 0 && st_clr[c]) flushed = 1'b1;
      if (flushed) begin
        e_data = '0; e_valid = 1'b0; e_hit = '0;
      end else begin
        e_data = st_data[j-5]; e_valid = st_valid[j-5]; e_hit = st_hit[j-5];
      end
      checks++;
      if (ob_valid[j] !== e_valid) begin
        errors++;
        $display("FAIL %s[%0d] data_out_valid got %b want %b", name, j, ob_valid[j], e_valid);
      end
      checks++;
      if (ob_pulse[j] !== e_hit) begin
        errors++;
        $display("FAIL %s[%0d] match_pulse got %b want %b", name, j, ob_pulse[j], e_hit);
      end
      if (flushed || e_valid) begin
        checks++;
        if (ob_data[j] !== e_data) begin
          errors++;
          $display("FAIL %s[%0d] data_out got %h want %h", name, j, ob_data[j], e_data);
        end
      end
    end
    st_n = 0;
  endtask

  task automatic check_flags(input string name, input logic [3:0] e_match, input logic e_any);
    checks++;
    if (match !== e_match) begin
      errors++;
      $display("FAIL %s match got %b want %b", name, match, e_match);
    end
    checks++;
    if (match_any !== e_any) begin
      errors++;
      $display("FAIL %s match_any got %b want %b", name, match_any, e_any);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({data_out, data_out_valid, match_pulse} !== '0) begin
      errors++;
      $display("FAIL %s outputs got %h/%b/%b want 0", name, data_out, data_out_valid, match_pulse);
    end
    check_flags(name, 4'b0000, 1'b0);
    checks++;
    if (match_count !== '0) begin
      errors++;
      $display("FAIL %s match_count got %h want 0", name, match_count);
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    check_idle_outputs("reset_idle");
  endtask

  task automatic test_passthrough;
    pattern_en = 4'b0000;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    push(32'h47455420, 1'b1, 1'b0, 4'h0);
    push(32'h2F204854, 1'b1, 1'b0, 4'h0);
    run_seq("passthrough");
    check_flags("passthrough", 4'b0000, 1'b0);
  endtask

  task automatic test_cross_word;
    pattern_en = 4'b0001;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    push(w("Host"), 1'b1, 1'b0, 4'b0000);
    push(w(": ww"), 1'b1, 1'b0, 4'b0000);
    push(w("w.pu"), 1'b1, 1'b0, 4'b0000);
    push(w("rdue"), 1'b1, 1'b0, 4'b0000);
    push(w(".edu"), 1'b1, 1'b0, 4'b0001);
    push(32'h0D0A0000, 1'b1, 1'b0, 4'b0000);
    run_seq("cross_word");
    check_flags("cross_word", 4'b0001, 1'b1);
    checks++;
    if (match_count[15:0] !== (CNT_EN ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL cross_word match_count[0] got %0d want %0d", match_count[15:0], CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_gaps_multi;
    logic [31:0] words [6];
    logic [3:0]  hits  [6];
    words = '{w("Host"), w(": ww"), w("w.pu"), w("rdue"), w(".edu"), 32'h0D0A0000};
    hits  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000};
    pattern_en = 4'b0111;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 6; i++) begin
      push(words[i], 1'b1, 1'b0, hits[i]);
      for (int g = 0; g < 3; g++) push(32'h0, 1'b0, 1'b0, 4'h0);
    end
    run_seq("gaps_multi");
    check_flags("gaps_multi", 4'b0111, 1'b1);
  endtask

  task automatic test_clear;
    pattern_en = 4'b0001;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    push(w("www."), 1'b1, 1'b0, 4'h0);
    push(w("purd"), 1'b1, 1'b0, 4'h0);
    push(32'hDEADBEEF, 1'b1, 1'b1, 4'h0);
    push(w("ue.e"), 1'b1, 1'b0, 4'h0);
    push(w("du"), 1'b1, 1'b0, 4'h0);
    run_seq("clear");
    check_flags("clear", 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid;
    pattern_en = 4'b0001;
    data_in = w("www."); data_in_valid = 1'b1;
    @(negedge clk);
    data_in = w("purd");
    @(negedge clk);
    data_in = '0; data_in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({data_out, data_out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid async data_out got %h/%b want 0", data_out, data_out_valid);
    end
    @(negedge clk);
    n_rst = 1'b1;
    push(w("ue.e"), 1'b1, 1'b0, 4'h0);
    push(w("du"), 1'b1, 1'b0, 4'h0);
    run_seq("reset_mid");
    check_flags("reset_mid", 4'b0000, 1'b0);
  endtask

  task automatic test_edge_config;
    set_pattern(2, "edu", 3);
    set_pattern(3, "edu", 0);
    pattern_en = 4'b1000;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    push(w(".edu"), 1'b1, 1'b0, 4'h0);
    push(w("Xedu"), 1'b1, 1'b0, 4'h0);
    run_seq("edge_config");
    check_flags("edge_config", 4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back;
    pattern_en = 4'b0100;
    push(32'h0, 1'b0, 1'b1, 4'h0);
    push(w(".edu"), 1'b1, 1'b0, 4'b0100);
    push(32'h0, 1'b0, 1'b0, 4'h0);
    push(w(".edu"), 1'b1, 1'b0, 4'b0100);
    push(w(".edu"), 1'b1, 1'b0, 4'b0100);
    run_seq("back_to_back");
    check_flags("back_to_back", 4'b0100, 1'b1);
    checks++;
    if (match_count[47:32] !== (CNT_EN ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL back_to_back match_count[2] got %0d want %0d", match_count[47:32], CNT_EN ? 3 : 0);
    end
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; data_in = '0; data_in_valid = 1'b0;
    patterns = '0; pattern_len = '0; pattern_en = '0;
    st_n = 0;
    set_pattern(0, "www.purdue.edu", 14);
    set_pattern(1, "Host", 4);
    set_pattern(2, "edu", 3);
    set_pattern(3, "zzzz", 4);
    test_reset();
    test_passthrough();
    test_cross_word();
    test_gaps_multi();
    test_clear();
    test_reset_mid();
    test_edge_config();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
